// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light controller and its lamp monitor:
// phase encoding, one-hot lamp patterns ({red, green, yellow}) and default hold lengths.
package traffic_light_pkg;

    localparam logic [1:0] PH_SYNC   = 2'd0;
    localparam logic [1:0] PH_RED    = 2'd1;
    localparam logic [1:0] PH_GREEN  = 2'd2;
    localparam logic [1:0] PH_YELLOW = 2'd3;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    localparam int DEF_RED_LEN    = 51;
    localparam int DEF_GREEN_LEN  = 51;
    localparam int DEF_YELLOW_LEN = 21;

    // Bit order matches the sticky flag vector {dur, order, illegal}.
    typedef struct packed {
        logic dur;
        logic order;
        logic illegal;
    } err_flags_t;

    function automatic logic lamp_one_hot(input logic [2:0] lamp);
        return (lamp == LAMP_RED) || (lamp == LAMP_GREEN) || (lamp == LAMP_YELLOW);
    endfunction

    function automatic logic [1:0] lamp_to_phase(input logic [2:0] lamp);
        logic [1:0] ph;
        case (lamp)
            LAMP_RED:    ph = PH_RED;
            LAMP_GREEN:  ph = PH_GREEN;
            LAMP_YELLOW: ph = PH_YELLOW;
            default:     ph = PH_SYNC;
        endcase
        return ph;
    endfunction

    // Lamp pattern that must follow a phase; SYNC has no legal successor.
    function automatic logic [2:0] next_lamp(input logic [1:0] ph);
        logic [2:0] lamp;
        case (ph)
            PH_RED:    lamp = LAMP_GREEN;
            PH_GREEN:  lamp = LAMP_YELLOW;
            PH_YELLOW: lamp = LAMP_RED;
            default:   lamp = 3'b000;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_phase_timer.sv
// Saturating phase-duration counter with load-to-1, plus the short/long
// comparison of the running duration against len -/+ TOL.
module phase_timer #(
    parameter int CNT_W = 8,
    parameter int TOL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             hold,
    input  logic [CNT_W-1:0] len,
    output logic             too_short,
    output logic             too_long
);

    localparam int CMP_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] DUR_MAX = '1;

    logic [CNT_W-1:0] dur_reg;
    logic [CNT_W-1:0] dur_next;
    logic [CMP_W-1:0] len_w;
    logic [CMP_W-1:0] tol_w;
    logic [CMP_W-1:0] min_w;
    logic [CMP_W-1:0] max_w;
    logic [CMP_W-1:0] dur_w;

    always_comb begin
        dur_next = dur_reg;
        if (clear) begin
            dur_next = '0;
        end else if (load) begin
            dur_next = CNT_W'(1);
        end else if (hold && (dur_reg != DUR_MAX)) begin
            dur_next = dur_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dur_reg <= '0;
        end else begin
            dur_reg <= dur_next;
        end
    end

    // One extra bit keeps len+TOL from wrapping; len-TOL floors at zero.
    assign len_w = {1'b0, len};
    assign tol_w = CMP_W'(TOL);
    assign dur_w = {1'b0, dur_reg};
    assign min_w = (len_w > tol_w) ? (len_w - tol_w) : '0;
    assign max_w = len_w + tol_w;

    assign too_short = (dur_w < min_w);
    assign too_long  = (dur_w == max_w);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-sequence checker: locks onto RED->GREEN->YELLOW->RED, checks hold
// times, and reports phase, lock, error pulses, sticky flags and completed cycles.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_LEN    = DEF_RED_LEN,
    parameter int GREEN_LEN  = DEF_GREEN_LEN,
    parameter int YELLOW_LEN = DEF_YELLOW_LEN,
    parameter int TOL        = 0,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        red,
    input  logic        yellow,
    input  logic        green,
    input  logic        err_clr,
    output logic [1:0]  phase,
    output logic        locked,
    output logic        err_illegal,
    output logic        err_order,
    output logic        err_dur,
    output logic [2:0]  err_sticky,
    output logic [15:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] RED_LEN_W    = CNT_W'(RED_LEN);
    localparam logic [CNT_W-1:0] GREEN_LEN_W  = CNT_W'(GREEN_LEN);
    localparam logic [CNT_W-1:0] YELLOW_LEN_W = CNT_W'(YELLOW_LEN);

    logic [2:0]       lamp_q_reg;
    logic [2:0]       lamp_prev_reg;
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             locked_reg;
    logic [15:0]      cycle_cnt_reg;
    logic [15:0]      cycle_cnt_next;
    err_flags_t       err_hit;
    logic [2:0]       err_hit_vec;
    logic [2:0]       err_pulse_reg;
    logic [2:0]       err_sticky_reg;

    logic             lamp_changed;
    logic             lamp_is_one_hot;
    logic             legal_step;
    logic             timer_clear;
    logic             timer_load;
    logic             timer_hold;
    logic             too_short;
    logic             too_long;
    logic [CNT_W-1:0] len_sel;

    assign lamp_changed    = (lamp_q_reg != lamp_prev_reg);
    assign lamp_is_one_hot = lamp_one_hot(lamp_q_reg);
    // next_lamp() of a non-one-hot previous sample is 000, so this also
    // requires both samples to be one-hot.
    assign legal_step      = lamp_changed && lamp_is_one_hot &&
                             (next_lamp(lamp_to_phase(lamp_prev_reg)) == lamp_q_reg);

    always_comb begin
        case (state_reg)
            PH_RED:    len_sel = RED_LEN_W;
            PH_GREEN:  len_sel = GREEN_LEN_W;
            PH_YELLOW: len_sel = YELLOW_LEN_W;
            default:   len_sel = '0;
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W),
        .TOL   (TOL)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .load      (timer_load),
        .hold      (timer_hold),
        .len       (len_sel),
        .too_short (too_short),
        .too_long  (too_long)
    );

    // Checks are mutually exclusive and ordered, so at most one error per sample.
    always_comb begin
        state_next     = state_reg;
        cycle_cnt_next = cycle_cnt_reg;
        err_hit        = '0;
        timer_clear    = 1'b0;
        timer_load     = 1'b0;
        timer_hold     = 1'b0;

        if (state_reg == PH_SYNC) begin
            if (legal_step) begin
                state_next = lamp_to_phase(lamp_q_reg);
                timer_load = 1'b1;
            end else begin
                timer_clear = 1'b1;
            end
        end else begin
            if (!lamp_is_one_hot) begin
                err_hit.illegal = 1'b1;
            end else if (lamp_changed && (lamp_q_reg != next_lamp(state_reg))) begin
                err_hit.order = 1'b1;
            end else if (lamp_changed && too_short) begin
                err_hit.dur = 1'b1;
            end else if (!lamp_changed && too_long) begin
                err_hit.dur = 1'b1;
            end else if (lamp_changed) begin
                state_next = lamp_to_phase(lamp_q_reg);
                timer_load = 1'b1;
                if (state_reg == PH_YELLOW) begin
                    cycle_cnt_next = cycle_cnt_reg + 16'd1;
                end
            end else begin
                timer_hold = 1'b1;
            end

            if (err_hit != '0) begin
                state_next  = PH_SYNC;
                timer_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_q_reg    <= 3'b000;
            lamp_prev_reg <= 3'b000;
            state_reg     <= PH_SYNC;
            locked_reg    <= 1'b0;
            cycle_cnt_reg <= '0;
            err_pulse_reg <= '0;
        end else begin
            lamp_q_reg    <= {red, green, yellow};
            lamp_prev_reg <= lamp_q_reg;
            state_reg     <= state_next;
            locked_reg    <= (state_next != PH_SYNC);
            cycle_cnt_reg <= cycle_cnt_next;
            err_pulse_reg <= err_hit_vec;
        end
    end

    assign err_hit_vec = err_hit;

    // A new error outranks a simultaneous clear.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
            always_ff @(posedge clk) begin
                if (rst) begin
                    err_sticky_reg[gi] <= 1'b0;
                end else if (err_hit_vec[gi]) begin
                    err_sticky_reg[gi] <= 1'b1;
                end else if (err_clr) begin
                    err_sticky_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign phase       = state_reg;
    assign locked      = locked_reg;
    assign err_dur     = err_pulse_reg[2];
    assign err_order   = err_pulse_reg[1];
    assign err_illegal = err_pulse_reg[0];
    assign err_sticky  = err_sticky_reg;
    assign cycle_cnt   = cycle_cnt_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: hand-computed vector table for the corner cases,
// then nominal and randomized lamp traffic checked every cycle against a run-length model.
module tb_traffic_light_monitor;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LG = 3'b010;
    localparam logic [2:0] LY = 3'b001;
    localparam logic [2:0] LRG = 3'b110;
    localparam logic [2:0] L0 = 3'b000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        red = 1'b0;
    logic        yellow = 1'b0;
    logic        green = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  phase;
    logic        locked;
    logic        err_illegal;
    logic        err_order;
    logic        err_dur;
    logic [2:0]  err_sticky;
    logic [15:0] cycle_cnt;

    traffic_light_monitor #(
        .RED_LEN    (51),
        .GREEN_LEN  (51),
        .YELLOW_LEN (21),
        .TOL        (0),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .err_clr     (err_clr),
        .phase       (phase),
        .locked      (locked),
        .err_illegal (err_illegal),
        .err_order   (err_order),
        .err_dur     (err_dur),
        .err_sticky  (err_sticky),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit seen_err = 1'b0;

    // Reference model: tracks run lengths of the sampled lamp stream.
    logic [2:0]  m_prev = 3'b000;
    logic [2:0]  m_lamp = 3'b000;
    bit          m_locked = 1'b0;
    int          m_run = 0;
    logic [15:0] m_cnt = '0;
    logic [2:0]  pend_err = '0;
    logic [1:0]  pend_ph = '0;
    bit          pend_lk = 1'b0;
    logic [15:0] pend_cnt = '0;
    logic [2:0]  exp_err = '0;
    logic [2:0]  exp_sticky = '0;
    logic [1:0]  exp_ph = '0;
    bit          exp_lk = 1'b0;
    logic [15:0] exp_cnt = '0;

    function automatic int hold_len(input logic [2:0] l);
        case (l)
            LR: return 51;
            LG: return 51;
            LY: return 21;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] l);
        case (l)
            LR: return LG;
            LG: return LY;
            LY: return LR;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] code(input logic [2:0] l);
        case (l)
            LR: return 2'd1;
            LG: return 2'd2;
            LY: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic bit onehot(input logic [2:0] l);
        return $countones(l) == 1;
    endfunction

    task automatic model_edge(input bit r, input logic [2:0] s, input bit c);
        bit changed;
        int prev_run;
        logic [2:0] e;
        if (r) begin
            m_prev = 3'b000; m_lamp = 3'b000; m_locked = 1'b0; m_run = 0; m_cnt = '0;
            pend_err = '0; pend_ph = '0; pend_lk = 1'b0; pend_cnt = '0;
            exp_err = '0; exp_sticky = '0; exp_ph = '0; exp_lk = 1'b0; exp_cnt = '0;
        end else begin
            exp_err    = pend_err;
            exp_sticky = (c ? 3'b000 : exp_sticky) | pend_err;
            exp_ph     = pend_ph;
            exp_lk     = pend_lk;
            exp_cnt    = pend_cnt;

            e = 3'b000;
            changed  = (s != m_prev);
            prev_run = m_run;
            m_run    = changed ? 1 : m_run + 1;
            if (!m_locked) begin
                if (changed && onehot(s) && onehot(m_prev) && succ(m_prev) == s) begin
                    m_locked = 1'b1;
                    m_lamp   = s;
                end
            end else if (!onehot(s)) begin
                e = 3'b001;
            end else if (changed && s != succ(m_lamp)) begin
                e = 3'b010;
            end else if (changed && prev_run < hold_len(m_lamp)) begin
                e = 3'b100;
            end else if (!changed && m_run > hold_len(m_lamp)) begin
                e = 3'b100;
            end else if (changed) begin
                if (m_lamp == LY) m_cnt = m_cnt + 16'd1;
                m_lamp = s;
            end
            if (e != 3'b000) m_locked = 1'b0;
            m_prev   = s;
            pend_err = e;
            pend_lk  = m_locked;
            pend_ph  = m_locked ? code(m_lamp) : 2'd0;
            pend_cnt = m_cnt;
        end
    endtask

    // One clock: drive inputs, let the model see the same edge, check on the falling edge.
    task automatic step(input bit r, input logic [2:0] l, input bit c);
        rst = r;
        {red, green, yellow} = l;
        err_clr = c;
        @(posedge clk);
        model_edge(r, l, c);
        @(negedge clk);
        tests++;
        if ({phase, locked, err_dur, err_order, err_illegal, err_sticky, cycle_cnt} !==
            {exp_ph, exp_lk, exp_err, exp_sticky, exp_cnt}) begin
            fails++;
            $display("FAIL model @%0t: dut ph=%0d lk=%0d err=%b sticky=%b cnt=%0d, required ph=%0d lk=%0d err=%b sticky=%b cnt=%0d",
                     $time, phase, locked, {err_dur, err_order, err_illegal}, err_sticky, cycle_cnt,
                     exp_ph, exp_lk, exp_err, exp_sticky, exp_cnt);
        end
        if (err_dur || err_order || err_illegal) seen_err = 1'b1;
    endtask

    task automatic check_val(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    typedef struct packed {
        logic        rst;
        logic [2:0]  lamp;
        logic        clr;
        int          n;
        logic [1:0]  ph;
        logic        lk;
        logic [2:0]  pulse;
        logic [2:0]  sticky;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [2:0] l, input logic c, input int n,
                                input logic [1:0] ph, input logic lk, input logic [2:0] p,
                                input logic [2:0] s, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.lamp = l; v.clr = c; v.n = n; v.ph = ph; v.lk = lk;
        v.pulse = p; v.sticky = s; v.cnt = cnt;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        // Each record: drive lamp for n cycles, then expect these outputs (pulse/sticky = {dur,order,illegal}).
        vecs.push_back(mk(1, L0, 0,  2, 0, 0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LR, 0, 30, 0, 0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LG, 0,  1, 0, 0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LG, 0,  1, 2, 1, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LG, 0, 49, 2, 1, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LY, 0,  2, 3, 1, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LY, 0, 19, 3, 1, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LR, 0,  2, 1, 1, 3'b000, 3'b000, 1));
        vecs.push_back(mk(0, LR, 0, 49, 1, 1, 3'b000, 3'b000, 1));
        // short green: 40 cycles
        vecs.push_back(mk(0, LG, 0,  2, 2, 1, 3'b000, 3'b000, 1));
        vecs.push_back(mk(0, LG, 0, 38, 2, 1, 3'b000, 3'b000, 1));
        vecs.push_back(mk(0, LY, 0,  1, 2, 1, 3'b000, 3'b000, 1));
        vecs.push_back(mk(0, LY, 0,  1, 0, 0, 3'b100, 3'b100, 1));
        vecs.push_back(mk(0, LY, 0,  1, 0, 0, 3'b000, 3'b100, 1));
        vecs.push_back(mk(0, LY, 0, 18, 0, 0, 3'b000, 3'b100, 1));
        // relock on Y->R, then stuck red
        vecs.push_back(mk(0, LR, 0,  2, 1, 1, 3'b000, 3'b100, 1));
        vecs.push_back(mk(0, LR, 0, 49, 1, 1, 3'b000, 3'b100, 1));
        vecs.push_back(mk(0, LR, 0,  1, 1, 1, 3'b000, 3'b100, 1));
        vecs.push_back(mk(0, LR, 0,  1, 0, 0, 3'b100, 3'b100, 1));
        vecs.push_back(mk(0, LR, 0,  7, 0, 0, 3'b000, 3'b100, 1));
        // full cycle, then R->Y with a simultaneous clear
        vecs.push_back(mk(0, LG, 0,  2, 2, 1, 3'b000, 3'b100, 1));
        vecs.push_back(mk(0, LG, 0, 49, 2, 1, 3'b000, 3'b100, 1));
        vecs.push_back(mk(0, LY, 0,  2, 3, 1, 3'b000, 3'b100, 1));
        vecs.push_back(mk(0, LY, 0, 19, 3, 1, 3'b000, 3'b100, 1));
        vecs.push_back(mk(0, LR, 0,  2, 1, 1, 3'b000, 3'b100, 2));
        vecs.push_back(mk(0, LR, 0, 49, 1, 1, 3'b000, 3'b100, 2));
        vecs.push_back(mk(0, LY, 0,  1, 1, 1, 3'b000, 3'b100, 2));
        vecs.push_back(mk(0, LY, 1,  1, 0, 0, 3'b010, 3'b010, 2));
        // relock, then red+green together with a simultaneous clear
        vecs.push_back(mk(0, LR, 0,  2, 1, 1, 3'b000, 3'b010, 2));
        vecs.push_back(mk(0, LRG, 0, 1, 1, 1, 3'b000, 3'b010, 2));
        vecs.push_back(mk(0, LRG, 1, 1, 0, 0, 3'b001, 3'b001, 2));
        vecs.push_back(mk(0, LR, 0,  1, 0, 0, 3'b000, 3'b001, 2));
        vecs.push_back(mk(0, LR, 0,  1, 0, 0, 3'b000, 3'b001, 2));
        // reset mid-green, then reacquire lock
        vecs.push_back(mk(0, LG, 0,  2, 2, 1, 3'b000, 3'b001, 2));
        vecs.push_back(mk(0, LG, 0, 10, 2, 1, 3'b000, 3'b001, 2));
        vecs.push_back(mk(1, L0, 0,  1, 0, 0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LG, 0,  2, 0, 0, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, LY, 0,  2, 3, 1, 3'b000, 3'b000, 0));

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].rst, vecs[i].lamp, vecs[i].clr);
            tests++;
            if ({phase, locked, err_dur, err_order, err_illegal, err_sticky, cycle_cnt} !==
                {vecs[i].ph, vecs[i].lk, vecs[i].pulse, vecs[i].sticky, vecs[i].cnt}) begin
                fails++;
                $display("FAIL vec%0d: dut ph=%0d lk=%0d err=%b sticky=%b cnt=%0d, required ph=%0d lk=%0d err=%b sticky=%b cnt=%0d",
                         i, phase, locked, {err_dur, err_order, err_illegal}, err_sticky, cycle_cnt,
                         vecs[i].ph, vecs[i].lk, vecs[i].pulse, vecs[i].sticky, vecs[i].cnt);
            end
            $display("[TB] vec %0d lamp=%b n=%0d -> ph=%0d lk=%0d err=%b sticky=%b cnt=%0d",
                     i, vecs[i].lamp, vecs[i].n, phase, locked,
                     {err_dur, err_order, err_illegal}, err_sticky, cycle_cnt);
        end

        // Three nominal controller cycles from reset.
        step(1, L0, 0);
        seen_err = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 51; k++) step(0, LR, 0);
            for (int k = 0; k < 51; k++) step(0, LG, 0);
            for (int k = 0; k < 21; k++) step(0, LY, 0);
        end
        check_val("nominal_cycle_cnt", cycle_cnt, 2);
        check_val("nominal_locked", locked, 1);
        check_val("nominal_phase", phase, 3);
        check_val("nominal_no_err", seen_err, 0);
        $display("[TB] nominal 3 cycles -> cnt=%0d lk=%0d ph=%0d", cycle_cnt, locked, phase);

        // Randomized segments: mostly legal successors with nominal or jittered holds.
        begin
            logic [2:0] cur;
            logic [2:0] nxt;
            int base;
            int n;
            cur = LY;
            for (int seg = 0; seg < 60; seg++) begin
                if ($urandom_range(29) == 0) step(1, L0, 0);
                nxt = ($urandom_range(9) < 8) ? succ(cur) : 3'($urandom_range(7));
                base = hold_len(nxt);
                if (base == 0) base = 4;
                case ($urandom_range(3))
                    0, 1: n = base;
                    2: n = base + int'($urandom_range(4)) - 2;
                    default: n = 1 + int'($urandom_range(69));
                endcase
                if (n < 1) n = 1;
                for (int k = 0; k < n; k++) step(0, nxt, $urandom_range(19) == 0);
                $display("[TB] seg %0d lamp=%b n=%0d -> ph=%0d lk=%0d sticky=%b cnt=%0d",
                         seg, nxt, n, phase, locked, err_sticky, cycle_cnt);
                cur = nxt;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
